// File: rtl/condicionador_entradas.sv
// condicionador_entradas
//   Input conditioning stage in front of the diabetes-detector data-entry FSM.
//   It turns raw slide switches and push keys into clean, single-cycle event
//   strobes in the ADC_CLK_10 domain:
//     - two-flop synchroniser on every raw input,
//     - tick-sampled debounce (a level must be seen on two consecutive ticks),
//     - a small IDLE/HOLD FSM that emits exactly one event per press.
//
// Ports
//   ADC_CLK_10   in   system clock (10 MHz), rising edge
//   reset_n      in   asynchronous active-low reset
//   SW[9:0]      in   raw slide switches, 1 = digit i selected
//   KEY[1:0]     in   raw push keys, active-low (KEY[0]=clear, KEY[1]=next)
//   digit_valid  out  one-cycle pulse, exactly one switch pressed
//   digit[3:0]   out  BCD index of that switch, held between pulses
//   next_pulse   out  one-cycle pulse, next key pressed
//   clear_pulse  out  one-cycle pulse, clear key pressed
//   multi_err    out  one-cycle pulse, more than one switch high at decision
//   sw_stable    out  debounced switch vector (drives LEDR)
module condicionador_entradas #(
  parameter int DEBOUNCE_CYCLES = 8192,
  parameter int CNT_W           = 13
) (
  input  logic        ADC_CLK_10,
  input  logic        reset_n,
  input  logic [9:0]  SW,
  input  logic [1:0]  KEY,
  output logic        digit_valid,
  output logic [3:0]  digit,
  output logic        next_pulse,
  output logic        clear_pulse,
  output logic        multi_err,
  output logic [9:0]  sw_stable
);

  // Keys are active-low, so their idle ("released") level is 1.
  // Bits [11:10] hold KEY, bits [9:0] hold SW.
  localparam logic [11:0] RELEASED = {2'b11, 10'b0};

  typedef enum logic {IDLE, HOLD} state_t;

  logic [11:0]      sync1_q, sync2_q;
  logic [11:0]      samp_q, stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic             tick, eval_q;
  state_t           state_q, state_d;

  logic             digitValid_q, digitValid_d;
  logic             nextPulse_q, nextPulse_d;
  logic             clearPulse_q, clearPulse_d;
  logic             multiErr_q, multiErr_d;
  logic [3:0]       digit_q, digit_d;

  logic [9:0]       stSw;
  logic [1:0]       stKey;
  logic [3:0]       swCount;
  logic [3:0]       swIndex;

  assign tick  = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign stSw  = stable_q[9:0];
  assign stKey = stable_q[11:10];

  // Two-flop synchroniser; resets to released levels so no phantom press
  // is seen right after reset.
  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
    end else begin
      sync1_q <= {KEY, SW};
      sync2_q <= sync1_q;
    end
  end

  // Free-running tick counter, and eval follows each tick by one cycle so
  // the FSM always sees the freshly updated stable vector.
  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      eval_q <= 1'b0;
    end else begin
      cnt_q  <= tick ? '0 : cnt_q + CNT_W'(1);
      eval_q <= tick;
    end
  end

  // A bit becomes stable only when two consecutive tick samples agree;
  // otherwise the previous stable value is kept.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 12; i++) begin
      if (sync2_q[i] == samp_q[i]) stable_d[i] = sync2_q[i];
    end
  end

  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      samp_q   <= RELEASED;
      stable_q <= RELEASED;
    end else if (tick) begin
      samp_q   <= sync2_q;
      stable_q <= stable_d;
    end
  end

  // Count the stable-high switches and remember the highest index; the
  // index is only used when exactly one switch is high.
  always_comb begin
    swCount = '0;
    swIndex = '0;
    for (int i = 0; i < 10; i++) begin
      if (stSw[i]) begin
        swCount = swCount + 4'd1;
        swIndex = 4'(i);
      end
    end
  end

  // Event decision. IDLE fires at most one prioritised event and moves to
  // HOLD; HOLD waits for everything to be released so a held input never
  // repeats.
  always_comb begin
    state_d      = state_q;
    digitValid_d = 1'b0;
    nextPulse_d  = 1'b0;
    clearPulse_d = 1'b0;
    multiErr_d   = 1'b0;
    digit_d      = digit_q;
    if (eval_q) begin
      case (state_q)
        IDLE: begin
          if (!stKey[0]) begin
            clearPulse_d = 1'b1;
            state_d      = HOLD;
          end else if (!stKey[1]) begin
            nextPulse_d = 1'b1;
            state_d     = HOLD;
          end else if (swCount == 4'd1) begin
            digitValid_d = 1'b1;
            digit_d      = swIndex;
            state_d      = HOLD;
          end else if (swCount > 4'd1) begin
            multiErr_d = 1'b1;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (stSw == 10'b0 && stKey == 2'b11) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      digitValid_q <= 1'b0;
      nextPulse_q  <= 1'b0;
      clearPulse_q <= 1'b0;
      multiErr_q   <= 1'b0;
      digit_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      digitValid_q <= digitValid_d;
      nextPulse_q  <= nextPulse_d;
      clearPulse_q <= clearPulse_d;
      multiErr_q   <= multiErr_d;
      digit_q      <= digit_d;
    end
  end

  assign digit_valid = digitValid_q;
  assign digit       = digit_q;
  assign next_pulse  = nextPulse_q;
  assign clear_pulse = clearPulse_q;
  assign multi_err   = multiErr_q;
  assign sw_stable   = stSw;

endmodule

// File: tb/tb_condicionador_entradas.sv
// Testbench for condicionador_entradas with a short debounce period.
// A behavioural reference model tracks what the outputs must be from the
// debounce/event rules; one compare process checks the DUT against it every
// cycle, and directed scenarios pin the model with hand-computed counts.
module tb_condicionador_entradas;

  localparam int D = 4;
  localparam logic [11:0] RELEASED = {2'b11, 10'b0};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] sw = 10'b0;
  logic [1:0] key = 2'b11;

  logic       digit_valid, next_pulse, clear_pulse, multi_err;
  logic [3:0] digit;
  logic [9:0] sw_stable;

  int vectors = 0;
  int miscompares = 0;

  condicionador_entradas #(.DEBOUNCE_CYCLES(D), .CNT_W(2)) dut (
    .ADC_CLK_10 (clk),
    .reset_n    (reset_n),
    .SW         (sw),
    .KEY        (key),
    .digit_valid(digit_valid),
    .digit      (digit),
    .next_pulse (next_pulse),
    .clear_pulse(clear_pulse),
    .multi_err  (multi_err),
    .sw_stable  (sw_stable)
  );

  always #5 clk = ~clk;

  // Reference model state: raw inputs seen at the last two edges, tick
  // phase, last tick sample, agreed (stable) levels and the "armed" flag
  // meaning no press is outstanding.
  logic [11:0] seen1, seen2, synced, lastSamp, stab;
  int          phase;
  bit          evalNow, armed;
  logic        mDigitValid, mNext, mClear, mMulti;
  logic [3:0]  mDigit;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seen1 = RELEASED; seen2 = RELEASED;
      lastSamp = RELEASED; stab = RELEASED;
      phase = 0; evalNow = 0; armed = 1;
      mDigitValid = 0; mNext = 0; mClear = 0; mMulti = 0; mDigit = 0;
    end else begin
      mDigitValid = 0; mNext = 0; mClear = 0; mMulti = 0;
      if (evalNow) begin
        if (armed) begin
          if (!stab[10]) begin
            mClear = 1; armed = 0;
          end else if (!stab[11]) begin
            mNext = 1; armed = 0;
          end else if ($countones(stab[9:0]) == 1) begin
            mDigitValid = 1; armed = 0;
            for (int b = 0; b < 10; b++) if (stab[b]) mDigit = 4'(b);
          end else if ($countones(stab[9:0]) > 1) begin
            mMulti = 1; armed = 0;
          end
        end else if (stab == RELEASED) begin
          armed = 1;
        end
      end
      synced = seen2;
      seen2 = seen1;
      seen1 = {key, sw};
      evalNow = (phase == D - 1);
      if (phase == D - 1) begin
        for (int b = 0; b < 12; b++) if (synced[b] == lastSamp[b]) stab[b] = synced[b];
        lastSamp = synced;
      end
      phase = (phase + 1) % D;
    end
  end

  // Observed event counters used by the directed scenarios.
  int cycle = 0;
  int digitCnt = 0, nextCnt = 0, clearCnt = 0, multiCnt = 0;
  int lastDigit = -1;
  int firstDigitCycle = -1;
  logic [9:0] stableSeen = 10'b0;

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    cycle++;
    vectors++;
    if ({digit_valid, digit, next_pulse, clear_pulse, multi_err, sw_stable} !==
        {mDigitValid, mDigit, mNext, mClear, mMulti, stab[9:0]}) begin
      miscompares++;
      $display("[TB] FAIL model t=%0t dv/dig/nx/clr/mul/sws got %b/%0d/%b/%b/%b/%b want %b/%0d/%b/%b/%b/%b",
               $time, digit_valid, digit, next_pulse, clear_pulse, multi_err, sw_stable,
               mDigitValid, mDigit, mNext, mClear, mMulti, stab[9:0]);
    end
    if (digit_valid === 1'b1) begin
      digitCnt++;
      lastDigit = int'(digit);
      if (firstDigitCycle < 0) firstDigitCycle = cycle;
    end
    if (next_pulse === 1'b1)  nextCnt++;
    if (clear_pulse === 1'b1) clearCnt++;
    if (multi_err === 1'b1)   multiCnt++;
    stableSeen = stableSeen | sw_stable;
  end

  task automatic applyStimulus(input logic [9:0] s, input logic [1:0] k, input int cycles);
    @(negedge clk);
    sw = s;
    key = k;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
    end
  endtask

  task automatic clearCounts();
    digitCnt = 0; nextCnt = 0; clearCnt = 0; multiCnt = 0;
    lastDigit = -1; firstDigitCycle = -1; stableSeen = 10'b0;
  endtask

  int t0;

  initial begin
    $display("[TB] start, DEBOUNCE_CYCLES=%0d", D);
    repeat (3) @(negedge clk);
    checkOutput("reset_pulses", int'({digit_valid, next_pulse, clear_pulse, multi_err}), 0);
    checkOutput("reset_digit", int'(digit), 0);
    checkOutput("reset_sw_stable", int'(sw_stable), 0);
    #2 reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single digit switch held.
    clearCounts();
    t0 = cycle + 1;
    applyStimulus(10'b0000001000, 2'b11, 20);
    checkOutput("sw3_digit_count", digitCnt, 1);
    checkOutput("sw3_digit_value", lastDigit, 3);
    checkOutput("sw3_latency_ok", int'(firstDigitCycle >= 0 && firstDigitCycle - t0 <= 14), 1);
    checkOutput("sw3_stable", int'(sw_stable), 10'h008);
    checkOutput("sw3_other_events", multiCnt + nextCnt + clearCnt, 0);
    applyStimulus(10'b0, 2'b11, 16);

    // Short glitch must be filtered out.
    clearCounts();
    applyStimulus(10'b0000100000, 2'b11, 3);
    applyStimulus(10'b0, 2'b11, 20);
    checkOutput("glitch_events", digitCnt + multiCnt + nextCnt + clearCnt, 0);
    checkOutput("glitch_stable_seen", int'(stableSeen), 0);

    // Two switches together, then one alone.
    clearCounts();
    applyStimulus(10'b0010000100, 2'b11, 20);
    checkOutput("multi_err_count", multiCnt, 1);
    checkOutput("multi_digit_count", digitCnt, 0);
    applyStimulus(10'b0, 2'b11, 16);
    clearCounts();
    applyStimulus(10'b0010000000, 2'b11, 20);
    checkOutput("sw7_digit_count", digitCnt, 1);
    checkOutput("sw7_digit_value", lastDigit, 7);
    applyStimulus(10'b0, 2'b11, 16);

    // Clear and next together: clear wins.
    clearCounts();
    applyStimulus(10'b0, 2'b00, 20);
    checkOutput("both_keys_clear", clearCnt, 1);
    checkOutput("both_keys_next", nextCnt, 0);
    applyStimulus(10'b0, 2'b11, 16);

    // Long hold of next, release, press again.
    clearCounts();
    applyStimulus(10'b0, 2'b01, 100);
    applyStimulus(10'b0, 2'b11, 16);
    applyStimulus(10'b0, 2'b01, 20);
    applyStimulus(10'b0, 2'b11, 16);
    checkOutput("next_two_presses", nextCnt, 2);
    checkOutput("next_no_clear", clearCnt, 0);

    // Reset in the middle of a held switch.
    clearCounts();
    applyStimulus(10'b1000000000, 2'b11, 20);
    checkOutput("sw9_first_press", digitCnt, 1);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midreset_pulses", int'({digit_valid, next_pulse, clear_pulse, multi_err}), 0);
    checkOutput("midreset_digit", int'(digit), 0);
    checkOutput("midreset_sw_stable", int'(sw_stable), 0);
    clearCounts();
    #2 reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("sw9_after_reset_count", digitCnt, 1);
    checkOutput("sw9_after_reset_value", lastDigit, 9);
    applyStimulus(10'b0, 2'b11, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
